// File: rtl/tmq_pkg.sv
// rtl/tmq_pkg.sv - shared constants and clamp helpers for the quantized LSTM output lane pipe
package tmq_pkg;

    localparam int IW = 48;

    localparam int DEF_SCALE_STATE       = 128;
    localparam int DEF_ZERO_STATE        = 128;
    localparam int DEF_SCALE_TANH        = 48;
    localparam int DEF_ZERO_TANH         = 128;
    localparam int DEF_OUT_SCALE_SIGMOID = 256;
    localparam int DEF_OUT_ZERO_SIGMOID  = 0;
    localparam int DEF_OUT_SCALE_TANH    = 128;
    localparam int DEF_SCALE_DATA        = 128;
    localparam int DEF_ZERO_DATA         = 128;

    // Clamp a signed intermediate into the unsigned code range [0, 2^dw-1].
    function automatic logic signed [IW-1:0] sat_val(input logic signed [IW-1:0] v, input int dw);
        logic signed [IW-1:0] max_v;
        max_v = {{(IW-1){1'b0}}, 1'b1};
        max_v = (max_v << dw) - max_v;
        if (v[IW-1])
            sat_val = '0;
        else if (v > max_v)
            sat_val = max_v;
        else
            sat_val = v;
    endfunction

    function automatic logic sat_hit(input logic signed [IW-1:0] v, input int dw);
        logic signed [IW-1:0] max_v;
        max_v = {{(IW-1){1'b0}}, 1'b1};
        max_v = (max_v << dw) - max_v;
        sat_hit = v[IW-1] | (v > max_v);
    endfunction

endpackage

// File: rtl/tmq_lane.sv
// rtl/tmq_lane.sv - one lane: Ct requantization to tanh domain and Ht = og * tanh(Ct) requantization
module tmq_lane
    import tmq_pkg::*;
#(
    parameter int DW                = 8,
    parameter int SCALE_STATE       = DEF_SCALE_STATE,
    parameter int ZERO_STATE        = DEF_ZERO_STATE,
    parameter int SCALE_TANH        = DEF_SCALE_TANH,
    parameter int ZERO_TANH         = DEF_ZERO_TANH,
    parameter int OUT_SCALE_SIGMOID = DEF_OUT_SCALE_SIGMOID,
    parameter int OUT_ZERO_SIGMOID  = DEF_OUT_ZERO_SIGMOID,
    parameter int OUT_SCALE_TANH    = DEF_OUT_SCALE_TANH,
    parameter int SCALE_DATA        = DEF_SCALE_DATA,
    parameter int ZERO_DATA         = DEF_ZERO_DATA
) (
    input  logic [DW-1:0] ct,
    input  logic [DW-1:0] og,
    input  logic [DW-1:0] lut_data,
    output logic [DW-1:0] addr,
    output logic [DW-1:0] ht,
    output logic          addr_sat,
    output logic          ht_sat
);

    localparam logic signed [IW-1:0] K_SS  = IW'(SCALE_STATE);
    localparam logic signed [IW-1:0] K_ZS  = IW'(ZERO_STATE);
    localparam logic signed [IW-1:0] K_ST  = IW'(SCALE_TANH);
    localparam logic signed [IW-1:0] K_ZT  = IW'(ZERO_TANH);
    localparam logic signed [IW-1:0] K_OZS = IW'(OUT_ZERO_SIGMOID);
    localparam logic signed [IW-1:0] K_SD  = IW'(SCALE_DATA);
    localparam logic signed [IW-1:0] K_ZD  = IW'(ZERO_DATA);
    localparam logic signed [IW-1:0] K_DEN = IW'(OUT_SCALE_TANH * OUT_SCALE_SIGMOID);

    logic signed [IW-1:0] ct_w, og_w, lut_w;
    logic signed [IW-1:0] addr_raw, ht_raw, addr_c, ht_c;

    assign ct_w  = $signed({{(IW-DW){1'b0}}, ct});
    assign og_w  = $signed({{(IW-DW){1'b0}}, og});
    assign lut_w = $signed({{(IW-DW){1'b0}}, lut_data});

    // Signed '/' truncates toward zero, which is the rounding the quantizer expects.
    assign addr_raw = (ct_w - K_ZS) * K_ST / K_SS + K_ZT;
    assign ht_raw   = (og_w - K_OZS) * (lut_w - K_ZT) * K_SD / K_DEN + K_ZD;

    assign addr_c   = sat_val(addr_raw, DW);
    assign ht_c     = sat_val(ht_raw, DW);
    assign addr     = DW'(addr_c);
    assign ht       = DW'(ht_c);
    assign addr_sat = sat_hit(addr_raw, DW);
    assign ht_sat   = sat_hit(ht_raw, DW);

endmodule

// File: rtl/tmq_lane_pipe.sv
// rtl/tmq_lane_pipe.sv - 3-stage LSTM output pipe: requantize Ct, read tanh LUT, produce Ht codes
module tmq_lane_pipe
    import tmq_pkg::*;
#(
    parameter int LANES             = 4,
    parameter int DW                = 8,
    parameter int SCALE_STATE       = DEF_SCALE_STATE,
    parameter int ZERO_STATE        = DEF_ZERO_STATE,
    parameter int SCALE_TANH        = DEF_SCALE_TANH,
    parameter int ZERO_TANH         = DEF_ZERO_TANH,
    parameter int OUT_SCALE_SIGMOID = DEF_OUT_SCALE_SIGMOID,
    parameter int OUT_ZERO_SIGMOID  = DEF_OUT_ZERO_SIGMOID,
    parameter int OUT_SCALE_TANH    = DEF_OUT_SCALE_TANH,
    parameter int SCALE_DATA        = DEF_SCALE_DATA,
    parameter int ZERO_DATA         = DEF_ZERO_DATA,
    parameter int CNT_W             = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [LANES*DW-1:0]   in_ct,
    input  logic [LANES*DW-1:0]   in_og,
    output logic                  lut_en,
    output logic [LANES*DW-1:0]   lut_addr,
    input  logic [LANES*DW-1:0]   lut_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [LANES*DW-1:0]   out_ht,
    output logic [LANES*DW-1:0]   out_ctq,
    input  logic                  cnt_clr,
    output logic [CNT_W-1:0]      sat_cnt
);

    localparam int W = LANES * DW;

    logic             adv;
    logic             s1_valid, s2_valid;
    logic [W-1:0]     s1_ct, s1_og, s2_og, s2_addr;
    logic [LANES-1:0] s2_asat;
    logic [W-1:0]     addr_w, ht_w;
    logic [LANES-1:0] asat_w, hsat_w;
    logic [CNT_W:0]   inc, sum;
    logic [CNT_W-1:0] sat_next;

    // One shared advance: the whole pipe moves or the whole pipe holds.
    assign adv      = !out_valid | out_ready;
    assign in_ready = adv;
    assign lut_en   = adv & s1_valid;
    assign lut_addr = addr_w;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        tmq_lane #(
            .DW(DW), .SCALE_STATE(SCALE_STATE), .ZERO_STATE(ZERO_STATE),
            .SCALE_TANH(SCALE_TANH), .ZERO_TANH(ZERO_TANH),
            .OUT_SCALE_SIGMOID(OUT_SCALE_SIGMOID), .OUT_ZERO_SIGMOID(OUT_ZERO_SIGMOID),
            .OUT_SCALE_TANH(OUT_SCALE_TANH), .SCALE_DATA(SCALE_DATA), .ZERO_DATA(ZERO_DATA)
        ) u_lane (
            .ct       (s1_ct[g*DW +: DW]),
            .og       (s2_og[g*DW +: DW]),
            .lut_data (lut_data[g*DW +: DW]),
            .addr     (addr_w[g*DW +: DW]),
            .ht       (ht_w[g*DW +: DW]),
            .addr_sat (asat_w[g]),
            .ht_sat   (hsat_w[g])
        );
    end

    // Address clamps are carried from S1 so both clamp kinds count at the S3 load.
    always_comb begin
        inc = '0;
        for (int i = 0; i < LANES; i++)
            inc = inc + (CNT_W+1)'(s2_asat[i]) + (CNT_W+1)'(hsat_w[i]);
        sum = {1'b0, sat_cnt} + inc;
        sat_next = sum[CNT_W] ? '1 : sum[CNT_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s2_valid  <= 1'b0;
            out_valid <= 1'b0;
            out_ht    <= '0;
            out_ctq   <= '0;
            sat_cnt   <= '0;
        end else begin
            if (adv) begin
                s1_valid  <= in_valid;
                s1_ct     <= in_ct;
                s1_og     <= in_og;
                s2_valid  <= s1_valid;
                s2_og     <= s1_og;
                s2_addr   <= addr_w;
                s2_asat   <= asat_w;
                out_valid <= s2_valid;
                if (s2_valid) begin
                    out_ht  <= ht_w;
                    out_ctq <= s2_addr;
                end
            end
            if (cnt_clr)
                sat_cnt <= '0;
            else if (adv && s2_valid)
                sat_cnt <= sat_next;
        end
    end

endmodule

// File: tb/tb_tmq_lane_pipe.sv
// tb/tb_tmq_lane_pipe.sv - randomized and directed bench for tmq_lane_pipe against an arithmetic model
module tb_tmq_lane_pipe;

    localparam int LANES = 4;
    localparam int DW    = 8;
    localparam int W     = LANES * DW;
    localparam int CWB   = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1, in_valid = 1'b0, out_ready = 1'b1, cnt_clr = 1'b0;
    logic [W-1:0] in_ct = '0, in_og = '0, lut_data;

    logic         in_ready_a, lut_en_a, out_valid_a;
    logic [W-1:0] lut_addr_a, out_ht_a, out_ctq_a;
    logic [15:0]  sat_cnt_a;
    logic         in_ready_b, lut_en_b, out_valid_b;
    logic [W-1:0] lut_addr_b, out_ht_b, out_ctq_b;
    logic [CWB-1:0] sat_cnt_b;

    tmq_lane_pipe u_dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a),
        .in_ct(in_ct), .in_og(in_og), .lut_en(lut_en_a), .lut_addr(lut_addr_a),
        .lut_data(lut_data), .out_valid(out_valid_a), .out_ready(out_ready),
        .out_ht(out_ht_a), .out_ctq(out_ctq_a), .cnt_clr(cnt_clr), .sat_cnt(sat_cnt_a)
    );

    tmq_lane_pipe #(.SCALE_DATA(512), .CNT_W(CWB)) u_dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b),
        .in_ct(in_ct), .in_og(in_og), .lut_en(lut_en_b), .lut_addr(lut_addr_b),
        .lut_data(lut_data), .out_valid(out_valid_b), .out_ready(out_ready),
        .out_ht(out_ht_b), .out_ctq(out_ctq_b), .cnt_clr(cnt_clr), .sat_cnt(sat_cnt_b)
    );

    typedef struct { logic [W-1:0] ht_a; logic [W-1:0] ht_b; logic [W-1:0] ctq; int nsat_b; } exp_t;
    typedef struct { logic [W-1:0] ht_a; logic [W-1:0] ht_b; logic [W-1:0] ctq_a; logic [W-1:0] ctq_b; } obs_t;

    logic [7:0]   lut_mem [256];
    logic         lut_en_s = 1'b0;
    logic [W-1:0] addr_s = '0;
    exp_t exp_q[$];
    obs_t obs_q[$];
    int n_checks = 0, n_fail = 0;

    function automatic int clamp8(input int v);
        if (v < 0) return 0;
        if (v > 255) return 255;
        return v;
    endfunction

    function automatic int addr_raw(input int ct);
        return ((ct - 128) * 48) / 128 + 128;
    endfunction

    function automatic int ht_raw(input int og, input int lut, input int sd);
        return (og * (lut - 128) * sd) / (128 * 256) + 128;
    endfunction

    function automatic exp_t model(input logic [W-1:0] ct, input logic [W-1:0] og);
        exp_t e;
        int a, lut, ha, hb;
        e.ht_a = '0; e.ht_b = '0; e.ctq = '0; e.nsat_b = 0;
        for (int l = 0; l < LANES; l++) begin
            a   = addr_raw(int'(ct[l*8 +: 8]));
            lut = int'(lut_mem[clamp8(a)]);
            ha  = ht_raw(int'(og[l*8 +: 8]), lut, 128);
            hb  = ht_raw(int'(og[l*8 +: 8]), lut, 512);
            e.ctq[l*8 +: 8]  = 8'(clamp8(a));
            e.ht_a[l*8 +: 8] = 8'(clamp8(ha));
            e.ht_b[l*8 +: 8] = 8'(clamp8(hb));
            e.nsat_b += ((a < 0 || a > 255) ? 1 : 0) + ((hb < 0 || hb > 255) ? 1 : 0);
        end
        return e;
    endfunction

    // LUT memory: answers the cycle after lut_en, holds otherwise.
    always @(negedge clk) begin
        lut_en_s <= lut_en_a;
        addr_s   <= lut_addr_a;
        if (!rst && in_valid && in_ready_a) exp_q.push_back(model(in_ct, in_og));
        if (!rst && out_valid_a && out_ready) obs_q.push_back('{out_ht_a, out_ht_b, out_ctq_a, out_ctq_b});
    end

    always @(posedge clk) begin
        if (rst) lut_data <= '0;
        else if (lut_en_s)
            for (int l = 0; l < LANES; l++) lut_data[l*8 +: 8] <= lut_mem[addr_s[l*8 +: 8]];
    end

    task automatic tick;
        @(posedge clk); #1;
    endtask

    task automatic send_beats(input int n, input logic [7:0] og);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1; in_ct = $urandom; in_og = {4{og}};
            tick;
        end
        in_valid = 1'b0;
    endtask

    task automatic fill_lut(input int v, input logic rnd);
        for (int i = 0; i < 256; i++) lut_mem[i] = rnd ? 8'($urandom) : 8'(v);
    endtask

    task automatic test_reset;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; cnt_clr = 1'b0;
        repeat (3) tick;
        rst = 1'b0;
        @(negedge clk);
        n_checks++; if (out_valid_a !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %0b want 0", out_valid_a); end
        n_checks++; if (out_ht_a !== '0) begin n_fail++; $display("FAIL reset_out_ht got %h want 0", out_ht_a); end
        n_checks++; if (out_ctq_a !== '0) begin n_fail++; $display("FAIL reset_out_ctq got %h want 0", out_ctq_a); end
        n_checks++; if (sat_cnt_a !== 16'd0 || sat_cnt_b !== 6'd0) begin n_fail++; $display("FAIL reset_sat_cnt got %0d/%0d want 0", sat_cnt_a, sat_cnt_b); end
        n_checks++; if (in_ready_a !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %0b want 1", in_ready_a); end
        n_checks++; if (lut_en_a !== 1'b0) begin n_fail++; $display("FAIL reset_lut_en got %0b want 0", lut_en_a); end
    endtask

    task automatic test_lut_addr;
        int r;
        logic [7:0] want3;
        exp_q.delete(); obs_q.delete();
        fill_lut(0, 1'b1);
        r = $urandom_range(0, 255);
        want3 = 8'(clamp8(addr_raw(r)));
        in_ct = {8'(r), 8'd0, 8'd255, 8'd128}; in_og = '0; in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        @(negedge clk);
        n_checks++; if (lut_en_a !== 1'b1) begin n_fail++; $display("FAIL lut_en_s1 got %0b want 1", lut_en_a); end
        n_checks++; if (lut_addr_a[7:0] !== 8'd128) begin n_fail++; $display("FAIL lut_addr_128 got %0d want 128", lut_addr_a[7:0]); end
        n_checks++; if (lut_addr_a[15:8] !== 8'd175) begin n_fail++; $display("FAIL lut_addr_255 got %0d want 175", lut_addr_a[15:8]); end
        n_checks++; if (lut_addr_a[23:16] !== 8'd80) begin n_fail++; $display("FAIL lut_addr_0 got %0d want 80", lut_addr_a[23:16]); end
        n_checks++; if (lut_addr_a[31:24] !== want3) begin n_fail++; $display("FAIL lut_addr_rand ct=%0d got %0d want %0d", r, lut_addr_a[31:24], want3); end
        repeat (4) tick;
        n_checks++; if (obs_q.size() != 1 || exp_q.size() != 1 || obs_q[0].ctq_a !== exp_q[0].ctq) begin
            n_fail++; $display("FAIL lut_addr_ctq got %0d beats want 1 matching ctq", obs_q.size()); end
        n_checks++; if (sat_cnt_a !== 16'd0 || sat_cnt_b !== 6'd0) begin n_fail++; $display("FAIL lut_addr_nosat got %0d/%0d want 0", sat_cnt_a, sat_cnt_b); end
    endtask

    task automatic test_ht_points;
        int og_t[3] = '{255, 0, 255};
        int lut_t[3] = '{255, 255, 0};
        int ea[3] = '{254, 128, 1};
        int eb[3] = '{255, 128, 0};
        logic [7:0] ogv, wa, wb;
        cnt_clr = 1'b1; tick; cnt_clr = 1'b0;
        for (int k = 0; k < 3; k++) begin
            fill_lut(lut_t[k], 1'b0);
            ogv = 8'(og_t[k]); wa = 8'(ea[k]); wb = 8'(eb[k]);
            in_ct = $urandom; in_og = {4{ogv}}; in_valid = 1'b1;
            tick;
            in_valid = 1'b0;
            for (int c = 1; c <= 3; c++) begin
                @(negedge clk);
                n_checks++; if (out_valid_a !== (c == 3)) begin n_fail++; $display("FAIL latency case%0d cycle%0d got %0b want %0b", k, c, out_valid_a, (c == 3)); end
            end
            n_checks++; if (out_ht_a !== {4{wa}}) begin n_fail++; $display("FAIL ht_point_a case%0d got %h want %h", k, out_ht_a, {4{wa}}); end
            n_checks++; if (out_ht_b !== {4{wb}}) begin n_fail++; $display("FAIL ht_point_b case%0d got %h want %h", k, out_ht_b, {4{wb}}); end
            tick;
        end
        repeat (2) tick;
        n_checks++; if (sat_cnt_b !== 6'd8) begin n_fail++; $display("FAIL ht_point_satcnt got %0d want 8", sat_cnt_b); end
        n_checks++; if (sat_cnt_a !== 16'd0) begin n_fail++; $display("FAIL ht_point_satcnt_a got %0d want 0", sat_cnt_a); end
    endtask

    task automatic test_back_to_back;
        int sent = 0;
        logic took, pstall = 1'b0;
        logic [W-1:0] pht = '0, pctq = '0;
        exp_q.delete(); obs_q.delete();
        fill_lut(0, 1'b1);
        in_ct = $urandom; in_og = $urandom;
        for (int c = 0; c < 30; c++) begin
            out_ready = !(c >= 4 && c <= 7);
            in_valid  = (sent < 10);
            @(negedge clk);
            took = in_valid && in_ready_a;
            if (out_valid_a && !out_ready) begin
                n_checks++; if (lut_en_a !== 1'b0) begin n_fail++; $display("FAIL stall_lut_en cycle%0d got %0b want 0", c, lut_en_a); end
                if (pstall) begin
                    n_checks++; if (out_ht_a !== pht || out_ctq_a !== pctq) begin
                        n_fail++; $display("FAIL stall_stable cycle%0d got %h/%h want %h/%h", c, out_ht_a, out_ctq_a, pht, pctq); end
                end
                pht = out_ht_a; pctq = out_ctq_a; pstall = 1'b1;
            end else pstall = 1'b0;
            @(posedge clk); #1;
            if (took) begin sent++; in_ct = $urandom; in_og = $urandom; end
        end
        in_valid = 1'b0; out_ready = 1'b1;
        n_checks++; if (obs_q.size() != 10 || exp_q.size() != 10) begin
            n_fail++; $display("FAIL b2b_count got %0d out/%0d in want 10", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (obs_q[i].ht_a !== exp_q[i].ht_a || obs_q[i].ht_b !== exp_q[i].ht_b || obs_q[i].ctq_a !== exp_q[i].ctq) begin
                n_fail++; $display("FAIL b2b_beat%0d got ht %h/%h ctq %h want ht %h/%h ctq %h", i,
                    obs_q[i].ht_a, obs_q[i].ht_b, obs_q[i].ctq_a, exp_q[i].ht_a, exp_q[i].ht_b, exp_q[i].ctq);
            end
        end
    endtask

    task automatic test_random_stream;
        int sent = 0, total = 0, want;
        logic took;
        cnt_clr = 1'b1; tick; cnt_clr = 1'b0;
        exp_q.delete(); obs_q.delete();
        fill_lut(0, 1'b1);
        in_ct = $urandom; in_og = $urandom;
        for (int c = 0; c < 3000 && obs_q.size() < 150; c++) begin
            in_valid  = (sent < 150) && ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 7);
            @(negedge clk);
            took = in_valid && in_ready_a;
            @(posedge clk); #1;
            if (took) begin sent++; in_ct = $urandom; in_og = $urandom; end
        end
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (2) tick;
        n_checks++; if (obs_q.size() != 150) begin n_fail++; $display("FAIL rand_count got %0d want 150", obs_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            total += exp_q[i].nsat_b;
            if (i < obs_q.size()) begin
                n_checks++;
                if (obs_q[i].ht_a !== exp_q[i].ht_a || obs_q[i].ht_b !== exp_q[i].ht_b ||
                    obs_q[i].ctq_a !== exp_q[i].ctq || obs_q[i].ctq_b !== exp_q[i].ctq) begin
                    n_fail++; $display("FAIL rand_beat%0d got ht %h/%h ctq %h want ht %h/%h ctq %h", i,
                        obs_q[i].ht_a, obs_q[i].ht_b, obs_q[i].ctq_a, exp_q[i].ht_a, exp_q[i].ht_b, exp_q[i].ctq);
                end
            end
        end
        want = (total > 63) ? 63 : total;
        n_checks++; if (int'(sat_cnt_b) != want) begin n_fail++; $display("FAIL rand_satcnt got %0d want %0d", sat_cnt_b, want); end
        n_checks++; if (sat_cnt_a !== 16'd0) begin n_fail++; $display("FAIL rand_satcnt_a got %0d want 0", sat_cnt_a); end
    endtask

    task automatic test_sat_counter;
        cnt_clr = 1'b1; tick; cnt_clr = 1'b0;
        out_ready = 1'b1;
        fill_lut(255, 1'b0);
        send_beats(15, 8'hFF); repeat (4) tick;
        n_checks++; if (sat_cnt_b !== 6'd60) begin n_fail++; $display("FAIL satcnt_60 got %0d want 60", sat_cnt_b); end
        send_beats(1, 8'hFF); repeat (4) tick;
        n_checks++; if (sat_cnt_b !== 6'd63) begin n_fail++; $display("FAIL satcnt_clamp got %0d want 63", sat_cnt_b); end
        send_beats(1, 8'hFF); repeat (4) tick;
        n_checks++; if (sat_cnt_b !== 6'd63) begin n_fail++; $display("FAIL satcnt_hold got %0d want 63", sat_cnt_b); end
        in_ct = $urandom; in_og = {4{8'hFF}}; in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        tick;
        cnt_clr = 1'b1;
        tick;
        cnt_clr = 1'b0;
        @(negedge clk);
        n_checks++; if (out_valid_a !== 1'b1) begin n_fail++; $display("FAIL clr_collide_load got %0b want 1", out_valid_a); end
        n_checks++; if (sat_cnt_b !== 6'd0) begin n_fail++; $display("FAIL clr_collide got %0d want 0", sat_cnt_b); end
        tick;
        send_beats(1, 8'hFF); repeat (4) tick;
        n_checks++; if (sat_cnt_b !== 6'd4) begin n_fail++; $display("FAIL satcnt_after_clr got %0d want 4", sat_cnt_b); end
    endtask

    task automatic test_reset_midstream;
        int seen = 0;
        out_ready = 1'b1;
        in_valid = 1'b1; in_ct = $urandom; in_og = $urandom;
        tick;
        in_ct = $urandom; in_og = $urandom;
        tick;
        in_valid = 1'b0; rst = 1'b1;
        obs_q.delete();
        tick;
        rst = 1'b0;
        @(negedge clk);
        n_checks++; if (out_valid_a !== 1'b0) begin n_fail++; $display("FAIL midrst_out_valid got %0b want 0", out_valid_a); end
        n_checks++; if (sat_cnt_b !== 6'd0) begin n_fail++; $display("FAIL midrst_satcnt got %0d want 0", sat_cnt_b); end
        n_checks++; if (out_ht_a !== '0) begin n_fail++; $display("FAIL midrst_out_ht got %h want 0", out_ht_a); end
        repeat (8) begin
            @(negedge clk);
            if (out_valid_a) seen++;
        end
        n_checks++; if (seen != 0 || obs_q.size() != 0) begin n_fail++; $display("FAIL midrst_stale got %0d valid cycles want 0", seen); end
    endtask

    initial begin
        test_reset;
        test_lut_addr;
        test_ht_points;
        test_back_to_back;
        test_random_stream;
        test_sat_counter;
        test_reset_midstream;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
